// File: rtl/mod_sub_arbiter_pkg.sv
// Shared constants for the SM2/NIST mod_sub arbiter: curve primes, curve-select
// encodings and FSM state encodings.
package mod_sub_arbiter_pkg;

  localparam int PRIME_W = 256;

  localparam logic [PRIME_W-1:0] SM2_P =
    256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff;
  localparam logic [PRIME_W-1:0] NIST_P =
    256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

  localparam logic CURVE_SM2  = 1'b0;
  localparam logic CURVE_NIST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [PRIME_W-1:0] curve_prime(input logic curve);
    return (curve == CURVE_NIST) ? NIST_P : SM2_P;
  endfunction

endpackage

// File: rtl/mod_sub_arbiter_mod_sub.sv
// Combinational modular subtraction: a - b, adding p back when the difference
// would go negative. Out-of-range operands are not corrected here.
module mod_sub #(
  parameter int W = 256
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic [W-1:0] mod_sub_res
);

  assign mod_sub_res = (a >= b) ? (a - b) : (a - b + p);

endmodule

// File: rtl/mod_sub_arbiter.sv
// Round-robin arbiter sharing one mod_sub datapath between NREQ requesters,
// returning a registered, ID-tagged result over a backpressured response channel.
module mod_sub_arbiter
  import mod_sub_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 256,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_curve,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_res,
  output logic              rsp_err,
  output logic              busy
);

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           grant;

  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;
  logic [W-1:0]   p_p0;
  logic [IDW-1:0] id_p0;
  logic [W-1:0]   diff;

  // Search starts just after the last winner, so it gets lowest priority next.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  last);
    logic           found;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!found && v[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  assign {pick_found, pick_idx} = rr_pick(req_valid, last_grant);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_found) state_nx = ST_CALC;
      ST_CALC: state_nx = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    grant     = (state == ST_IDLE) && !rst && pick_found;
    req_ready = '0;
    if (grant) req_ready = NREQ'(1) << pick_idx;
    busy      = (state != ST_IDLE);
  end

  // Stage p0: operands and prime captured on the grant cycle only.
  always_ff @(posedge clk) begin
    if (grant) begin
      a_p0  <= req_a[int'(pick_idx)*W +: W];
      b_p0  <= req_b[int'(pick_idx)*W +: W];
      p_p0  <= W'(curve_prime(req_curve[pick_idx]));
      id_p0 <= pick_idx;
    end
  end

  mod_sub #(.W(W)) u_mod_sub (
    .a           (a_p0),
    .b           (b_p0),
    .p           (p_p0),
    .mod_sub_res (diff)
  );

  // Stage p1: registered response, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
      rsp_valid  <= 1'b0;
      rsp_res    <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (grant) last_grant <= pick_idx;
      if (state == ST_CALC) begin
        rsp_valid <= 1'b1;
        rsp_res   <= diff;
        rsp_id    <= id_p0;
        rsp_err   <= (a_p0 >= p_p0) | (b_p0 >= p_p0);
      end else if (state == ST_HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_sub_arbiter.sv
// Randomized and directed bench for mod_sub_arbiter against a transaction-level
// reference model (round-robin order and modular arithmetic).
module tb_mod_sub_arbiter;
  import mod_sub_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 256;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_curve;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_res;
  logic              rsp_err;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int last_g = NREQ - 1;

  always #5 clk = ~clk;

  mod_sub_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_curve (req_curve),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // (a - b) mod p; true modulo for in-range operands, raw rule otherwise.
  function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] p);
    logic [W:0] s;
    if (a < p && b < p) begin
      s = {1'b0, a} + {1'b0, p} - {1'b0, b};
      return W'(s % {1'b0, p});
    end
    if (a >= b) return a - b;
    return a - b + p;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    req_valid[i]       = 1'b1;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_curve[i]       = c;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc();
    cyc();
    rst       = 1'b0;
    last_g    = NREQ - 1;
  endtask

  // One full transaction from the current IDLE cycle through the response.
  task automatic run_op(input bit keep, input int hold, output logic [W-1:0] res_o,
                        output int id_o, output bit err_o, output int gcyc);
    int           g;
    int           waited;
    logic [W-1:0] ea, eb, ep, er, oh;
    bit           ee;
    res_o = '0; id_o = -1; err_o = 1'b0; gcyc = cyc_cnt;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      cyc();
      #1;
      waited++;
    end
    if (req_ready == '0) begin
      check_eq("grant_timeout", 0, 1);
      return;
    end
    g  = model_grant(req_valid, last_g);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    check_eq("grant", W'(req_ready), oh);
    if (g < 0) return;
    gcyc   = cyc_cnt;
    ea     = req_a[g*W +: W];
    eb     = req_b[g*W +: W];
    ep     = req_curve[g] ? NIST_P : SM2_P;
    er     = model_res(ea, eb, ep);
    ee     = (ea >= ep) || (eb >= ep);
    last_g = g;
    rsp_ready = (hold == 0);
    cyc();
    if (!keep) req_valid[g] = 1'b0;
    req_a[g*W +: W] = rnd256();
    req_b[g*W +: W] = rnd256();
    #1;
    check_eq("calc_busy", W'(busy), 1);
    check_eq("calc_rsp_valid", W'(rsp_valid), 0);
    check_eq("calc_req_ready", W'(req_ready), 0);
    cyc();
    check_eq("rsp_valid", W'(rsp_valid), 1);
    check_eq("rsp_res", rsp_res, er);
    check_eq("rsp_id", W'(rsp_id), W'(g));
    check_eq("rsp_err", W'(rsp_err), W'(ee));
    res_o = rsp_res; id_o = int'(rsp_id); err_o = rsp_err;
    for (int h = 0; h < hold; h++) begin
      cyc();
      check_eq("hold_valid", W'(rsp_valid), 1);
      check_eq("hold_res", rsp_res, er);
      check_eq("hold_id", W'(rsp_id), W'(g));
      check_eq("hold_req_ready", W'(req_ready), 0);
      check_eq("hold_busy", W'(busy), 1);
    end
    rsp_ready = 1'b1;
    cyc();
    check_eq("done_valid", W'(rsp_valid), 0);
    check_eq("done_busy", W'(busy), 0);
  endtask

  initial begin
    logic [W-1:0] res, a, b, oh;
    int           id, gc, prev_gc, g;
    bit           err;
    int           seq[5];
    seq = '{0, 1, 2, 3, 0};

    // Reset state, with every requester asking during reset.
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_curve = '0;
    req_valid = '1;
    cyc();
    cyc();
    check_eq("rst_req_ready", W'(req_ready), 0);
    check_eq("rst_rsp_valid", W'(rsp_valid), 0);
    check_eq("rst_rsp_res", rsp_res, 0);
    check_eq("rst_rsp_id", W'(rsp_id), 0);
    check_eq("rst_rsp_err", W'(rsp_err), 0);
    check_eq("rst_busy", W'(busy), 0);
    do_reset();

    // NIST vector on requester 0.
    set_req(0, 256'h73ba39a534ef8fcb0c982589952e0071c3c87cafdf0eb28e2b3a73ac6e941a16,
               256'ha756ec029d72eda1eecac889de78c41637af78456637461f0e8895d8bb5d5e9b, CURVE_NIST);
    run_op(0, 0, res, id, err, gc);
    check_eq("nist_res", res, 256'hcc634da1977ca22a1dcd5cffb6b53c5b8c19046b78d76c6f1cb1ddd3b336bb7a);
    check_eq("nist_id", W'(id), 0);
    check_eq("nist_err", W'(err), 0);

    // SM2 vector on requester 2.
    set_req(2, 256'hc239507105c683242a81052ff641ed69009a084ad5cc937db21646cd34a0ced5,
               256'hb1bf7ec4080f3c8735f1294ac0db19686bee2e96ab8c71fb7a253666cb66e009, CURVE_SM2);
    run_op(0, 0, res, id, err, gc);
    check_eq("sm2_res", res, 256'h1079d1acfdb7469cf48fdbe53566d40094abd9b42a40218237f110666939eecc);
    check_eq("sm2_id", W'(id), 2);

    // Fairness: all four held high from a fresh reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, rnd256() >> 1, rnd256() >> 1, 1'($urandom_range(0, 1)));
    prev_gc = 0;
    for (int n = 0; n < 5; n++) begin
      run_op(1, 0, res, id, err, gc);
      check_eq("fair_order", W'(id), W'(seq[n]));
      if (n > 0) check_eq("fair_spacing", W'(gc - prev_gc), 3);
      prev_gc = gc;
    end
    req_valid = '0;

    // Backpressure for 10 cycles, with another requester waiting.
    set_req(1, rnd256() >> 1, rnd256() >> 1, CURVE_SM2);
    set_req(3, rnd256() >> 1, rnd256() >> 1, CURVE_NIST);
    run_op(0, 10, res, id, err, gc);
    #1;
    g  = model_grant(req_valid, last_g);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    check_eq("bp_regrant", W'(req_ready), oh);
    run_op(0, 0, res, id, err, gc);

    // Boundaries.
    a = rnd256() >> 1;
    set_req(2, a, a, CURVE_NIST);
    run_op(0, 0, res, id, err, gc);
    check_eq("bnd_equal", res, 0);
    set_req(1, 0, 1, CURVE_SM2);
    run_op(0, 0, res, id, err, gc);
    check_eq("bnd_wrap", res, SM2_P - 1);
    set_req(0, NIST_P, 0, CURVE_NIST);
    run_op(0, 0, res, id, err, gc);
    check_eq("bnd_err", W'(err), 1);

    // Reset asserted while in CALC.
    do_reset();
    set_req(0, rnd256() >> 1, rnd256() >> 1, CURVE_SM2);
    #1;
    check_eq("mid_grant", W'(req_ready), 1);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    last_g = NREQ - 1;
    check_eq("mid_rsp_valid", W'(rsp_valid), 0);
    check_eq("mid_busy", W'(busy), 0);
    cyc();
    check_eq("mid_rsp_valid2", W'(rsp_valid), 0);
    set_req(1, rnd256() >> 1, rnd256() >> 1, CURVE_NIST);
    set_req(0, rnd256() >> 1, rnd256() >> 1, CURVE_SM2);
    run_op(0, 0, res, id, err, gc);
    check_eq("mid_first_id", W'(id), 0);
    req_valid = '0;

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int mask;
      mask = $urandom_range(1, (1 << NREQ) - 1);
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          logic c;
          c = 1'($urandom_range(0, 1));
          a = rnd256();
          b = rnd256();
          if ($urandom_range(0, 7) == 0) a = (c ? NIST_P : SM2_P) + W'($urandom_range(0, 100));
          if ($urandom_range(0, 7) == 0) b = a;
          set_req(i, a, b, c);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), res, id, err, gc);
    end
    req_valid = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod_sub_arbiter.md
Name: mod_sub_arbiter

Overview:
- Shares one combinational mod_sub datapath (a, b, p -> mod_sub_res = (a - b) mod p) between NREQ requesters in the SM2/NIST point-arithmetic engine.
- Each requester presents two 256-bit operands and a curve select over a valid/ready handshake.
- The block arbitrates round-robin, registers the operands, drives mod_sub with the selected prime, and returns a registered result tagged with the requester ID over a single response channel with backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 256, operand and result width.
- IDW, 2, width of rsp_id; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot grant; the handshake completes on the cycle where req_valid[i] and req_ready[i] are both 1.
- req_a  input  NREQ*W  minuend; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  subtrahend, same packing as req_a.
- req_curve  input  NREQ  prime select: 0 = SM2_P, 1 = NIST_P.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_res  output  W  (a - b) mod p.
- rsp_err  output  1  operand out of range (a >= p or b >= p).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state = IDLE, rsp_valid = 0, rsp_res = 0, rsp_id = 0, rsp_err = 0, busy = 0, last_grant = NREQ-1 (first grant goes to requester 0). req_ready = 0 while rst is high.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - req_ready is combinational: one-hot for the first requester with req_valid set, searching from last_grant+1 with wrap-around modulo NREQ. If no requester is valid, req_ready = 0.
  - On grant g: latch a_r = req_a[g], b_r = req_b[g], p_r = (req_curve[g] ? NIST_P : SM2_P), id_r = g; set last_grant = g; go to CALC.
- CALC: mod_sub is driven from a_r, b_r, p_r. Register rsp_res = mod_sub_res, rsp_id = id_r, rsp_err = (a_r >= p_r) | (b_r >= p_r), rsp_valid = 1. Go to HOLD.
- HOLD:
  - rsp_valid, rsp_res, rsp_id and rsp_err hold stable until rsp_ready = 1.
  - On that cycle: rsp_valid = 0 next cycle and state goes to IDLE.
  - No req_ready is asserted outside IDLE.
- Latency: grant at cycle T gives rsp_valid at T+2. Peak throughput is 1 operation per 3 cycles with rsp_ready held high.
- Arithmetic: mod_sub computes a-b if a >= b, else a-b+p, truncated to W bits. With out-of-range operands the result is whatever mod_sub produces; rsp_err flags it and the block does not correct it.
- Requests:
  - A requester that drops req_valid before being granted is simply skipped.
  - Operands are sampled only on the grant cycle; later changes are ignored.
  - Simultaneous requests are resolved by round-robin only. After granting g, requester g has the lowest priority in the next arbitration.
- Reset mid-operation (CALC or HOLD): state returns to IDLE, the pending result is discarded, and rsp_valid = 0 on the cycle after rst.

Decomposition:
- Shared package/include holds SM2_P = 256'hfffffffeffffffffffffffffffffffffffffffff00000000ffffffffffffffff, NIST_P = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff, curve-select encodings (CURVE_SM2 = 0, CURVE_NIST = 1) and FSM state encodings.
- Sub-module: the existing mod_sub, instantiated once (ports a, b, p, mod_sub_res).
- The round-robin picker stays inline (a priority rotate-and-encode function).

Test Plan:
1. NIST vector:
   - Stimulus: req0, curve = 1, a = 73ba39a534ef8fcb0c982589952e0071c3c87cafdf0eb28e2b3a73ac6e941a16, b = a756ec029d72eda1eecac889de78c41637af78456637461f0e8895d8bb5d5e9b, rsp_ready = 1.
   - Required: rsp_valid 2 cycles after the grant, rsp_res = cc634da1977ca22a1dcd5cffb6b53c5b8c19046b78d76c6f1cb1ddd3b336bb7a, rsp_id = 0, rsp_err = 0.
2. SM2 vector:
   - Stimulus: req2, curve = 0, a = c239507105c683242a81052ff641ed69009a084ad5cc937db21646cd34a0ced5, b = b1bf7ec4080f3c8735f1294ac0db19686bee2e96ab8c71fb7a253666cb66e009.
   - Required: rsp_res = 1079d1acfdb7469cf48fdbe53566d40094abd9b42a40218237f110666939eecc, rsp_id = 2.
3. Fairness: all four req_valid held high, rsp_ready = 1. Required: grants in order 0, 1, 2, 3, 0, spaced 3 cycles apart; rsp_id follows the same order.
4. Backpressure: rsp_ready = 0 for 10 cycles while in HOLD. Required: rsp_valid/rsp_res/rsp_id stable, req_ready = 0, busy = 1; one cycle after rsp_ready = 1, rsp_valid = 0 and a new grant is issued in IDLE.
5. Boundaries:
   - a = b -> rsp_res = 0.
   - a = 0, b = 1, SM2 -> rsp_res = SM2_P - 1.
   - a = NIST_P, b = 0 -> rsp_err = 1.
6. Reset mid-operation: rst asserted in CALC. Required: no rsp_valid pulse; the first post-reset request from req1 and req0 together grants req0.
